master_port_burst: RTL
======================

MASTER_PORT_BURST -- requirements
Module: master_port_burst

Interface
REQ-001 Parameter ADDR_W, default 16, address bits shifted per transaction.
REQ-002 Parameter DATA_W, default 8, data bits per beat.
REQ-003 Parameter LEN_W, default 4, width of burst-length field; beats = m_len+1 (1..2^LEN_W).
REQ-004 Parameter TIMEOUT, default 255, idle cycles tolerated without a bus handshake before abort.
REQ-005 Ports, one per line:
  clk  in  1  single clock, rising edge.
  rstn  in  1  reset, asynchronous, active-low.
  mode  out  1  latched transaction direction (1 = write), 0 when idle.
  wr_bus  out  1  serial write line (address / write-data MSB first).
  rd_bus  in  1  serial read line from slave.
  master_valid  out  1  wr_bus bit valid.
  slave_ready  in  1  slave accepts bit / request.
  master_ready  out  1  master accepts rd_bus bit.
  slave_valid  in  1  rd_bus bit valid.
  m_start  in  1  start request, sampled only in IDLE.
  m_mode  in  1  requested direction (1 = write).
  m_addr  in  ADDR_W  start address.
  m_len  in  LEN_W  beats minus one.
  m_wr_data  in  DATA_W  write word.
  m_wr_ack  out  1  m_wr_data consumed this cycle.
  m_rd_data  out  DATA_W  assembled read word.
  m_rd_valid  out  1  one-cycle strobe, m_rd_data valid.
  m_busy  out  1  transaction in progress.
  m_done  out  1  one-cycle end-of-transaction strobe.
  m_err  out  1  qualifies m_done: transaction aborted by timeout.

Function
REQ-006 FSM states SHALL be IDLE, REQ, ADDR, WR_DATA, RD_DATA, DONE, ERR; m_busy = (state != IDLE).
REQ-007 IDLE & m_start: latch m_addr, m_mode, m_len, m_wr_data; assert m_wr_ack that cycle if m_mode=1; go REQ.
REQ-008 REQ: outputs master_valid=0, master_ready=0; slave_ready=1 -> ADDR next cycle.
REQ-009 ADDR: master_valid=1, wr_bus=addr MSB; each cycle with slave_ready=1 shifts address left one bit; after ADDR_W handshakes -> WR_DATA if mode=1 else RD_DATA.
REQ-010 WR_DATA: master_valid=1, wr_bus=data MSB; each slave_ready=1 cycle shifts one bit; on DATA_W-th bit of a non-final beat, load m_wr_data into the shifter and pulse m_wr_ack the same cycle; final beat's last bit -> DONE.
REQ-011 RD_DATA: master_ready=1; each slave_valid=1 cycle shifts rd_bus in at LSB; on DATA_W-th bit, m_rd_data updates and m_rd_valid pulses next cycle; final beat -> DONE.
REQ-012 Bit counter SHALL be wide enough for max(ADDR_W, DATA_W) and reset at each phase/beat boundary; beat counter counts down from m_len, no wrap.
REQ-013 DONE: m_done=1, m_err=0 for one cycle -> IDLE; ERR: m_done=1, m_err=1 for one cycle -> IDLE.
REQ-014 Timeout counter clears on entering REQ and on every bus handshake; increments otherwise in REQ/ADDR/WR_DATA/RD_DATA; reaching TIMEOUT -> ERR, no further bus bits driven.
REQ-015 mode SHALL hold latched direction from REQ through DONE/ERR, 0 in IDLE; wr_bus=0 outside ADDR/WR_DATA.
REQ-016 m_start outside IDLE SHALL be ignored; m_start in the DONE/ERR cycle ignored.
REQ-017 m_rd_data SHALL hold last completed word until next read word completes.

Reset
REQ-018 rstn=0 SHALL asynchronously force IDLE and all outputs, shifters and counters to 0, including mid-transaction; no m_done issued for the aborted transfer.
REQ-019 First m_start after rstn release SHALL be accepted normally.

Verification
REQ-020 Single write, ADDR_W=16, DATA_W=8, m_addr=16'hA5C3, m_wr_data=8'h96, m_len=0, slave_ready=1 -> wr_bus emits A5C3 then 96 MSB first over 24 cycles, m_done=1, m_err=0.
REQ-021 Read burst m_len=2, slave drives 8'h3C, 8'hF0, 8'h81 -> three m_rd_valid strobes with those values in order, then one m_done.
REQ-022 Write burst m_len=1 with slave_ready toggling 1/0 -> m_wr_ack exactly twice, bits unchanged across stalled cycles, data 8'h11 then 8'h22 on wr_bus.
REQ-023 TIMEOUT=4, slave_ready held 0 in ADDR -> ERR after 4 stall cycles, m_done=1 with m_err=1, return to IDLE, master_valid=0.
REQ-024 rstn pulled low mid-WR_DATA -> all outputs 0 immediately, no m_done; next m_start completes a clean transaction.
REQ-025 m_start pulsed while m_busy=1 -> ignored, current transfer unaffected, exactly one m_done.

Source files
------------

// File: rtl/master_port_burst.sv
// Burst master for a bit-serial valid/ready bus: sends an address MSB first, then
// writes or reads len+1 data words, aborting to ERR when the slave goes silent.
module master_port_burst #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              mode,
  output logic              wr_bus,
  input  logic              rd_bus,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              master_ready,
  input  logic              slave_valid,
  input  logic              m_start,
  input  logic              m_mode,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [LEN_W-1:0]  m_len,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic              m_wr_ack,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_busy,
  output logic              m_done,
  output logic              m_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BIT_W = $clog2(MAX_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, WR_DATA, RD_DATA, DONE, ERR} state_t;

  state_t              state;
  logic                mode_reg;
  logic [ADDR_W-1:0]   addr_sh;
  logic [DATA_W-1:0]   data_sh;
  logic [DATA_W-2:0]   rd_sh;
  logic [BIT_W-1:0]    bit_cnt;
  logic [LEN_W-1:0]    beat_cnt;
  logic [TO_W-1:0]     timeout_cnt;
  logic                rd_valid_reg;

  logic                last_addr_bit;
  logic                last_data_bit;
  logic                last_beat;
  logic                stall_limit;
  logic [DATA_W-1:0]   rd_word;

  assign last_addr_bit = (bit_cnt == BIT_W'(ADDR_W - 1));
  assign last_data_bit = (bit_cnt == BIT_W'(DATA_W - 1));
  assign last_beat     = (beat_cnt == '0);
  assign stall_limit   = (timeout_cnt == TO_W'(TIMEOUT - 1));
  assign rd_word       = {rd_sh, rd_bus};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      mode_reg     <= 1'b0;
      addr_sh      <= '0;
      data_sh      <= '0;
      rd_sh        <= '0;
      bit_cnt      <= '0;
      beat_cnt     <= '0;
      timeout_cnt  <= '0;
      rd_valid_reg <= 1'b0;
      m_rd_data    <= '0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (m_start) begin
            addr_sh     <= m_addr;
            data_sh     <= m_wr_data;
            mode_reg    <= m_mode;
            beat_cnt    <= m_len;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (slave_ready) begin
            timeout_cnt <= '0;
            state       <= ADDR;
          end else if (stall_limit) begin
            state <= ERR;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ADDR: begin
          if (slave_ready) begin
            timeout_cnt <= '0;
            addr_sh     <= {addr_sh[ADDR_W-2:0], 1'b0};
            if (last_addr_bit) begin
              bit_cnt <= '0;
              state   <= mode_reg ? WR_DATA : RD_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (stall_limit) begin
            state <= ERR;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        WR_DATA: begin
          if (slave_ready) begin
            timeout_cnt <= '0;
            if (last_data_bit) begin
              bit_cnt <= '0;
              if (last_beat) begin
                state <= DONE;
              end else begin
                // Next word is taken on the same cycle m_wr_ack is high.
                data_sh  <= m_wr_data;
                beat_cnt <= beat_cnt - 1'b1;
              end
            end else begin
              data_sh <= {data_sh[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (stall_limit) begin
            state <= ERR;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (slave_valid) begin
            timeout_cnt <= '0;
            rd_sh       <= rd_word[DATA_W-2:0];
            if (last_data_bit) begin
              m_rd_data    <= rd_word;
              rd_valid_reg <= 1'b1;
              bit_cnt      <= '0;
              if (last_beat) state <= DONE;
              else           beat_cnt <= beat_cnt - 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (stall_limit) begin
            state <= ERR;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        DONE, ERR: begin
          mode_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mode         = mode_reg;
  assign m_busy       = (state != IDLE);
  assign master_valid = (state == ADDR) || (state == WR_DATA);
  assign master_ready = (state == RD_DATA);
  assign wr_bus       = (state == ADDR)    ? addr_sh[ADDR_W-1] :
                        (state == WR_DATA) ? data_sh[DATA_W-1] : 1'b0;
  assign m_done       = (state == DONE) || (state == ERR);
  assign m_err        = (state == ERR);
  assign m_rd_valid   = rd_valid_reg;
  assign m_wr_ack     = ((state == IDLE) && m_start && m_mode) ||
                        ((state == WR_DATA) && slave_ready && last_data_bit && !last_beat);

endmodule
